uart_cmd_deframer: RTL

Byte-to-command deframer sitting directly downstream of the UART receiver. It consumes received bytes via the receiver's `rdy`/`clr_rdy` handshake and hunts for a sync byte. It then assembles a 5-byte frame (sync, opcode, data high, data low, checksum) and presents validated 8-bit opcode plus 16-bit data to the command processor. Corrupt, stalled and overrun frames are flagged with one-cycle pulses.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/byte_tmo_timer.sv | 35 +++
 rtl/uart_cmd_deframer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command deframer: FSM states,
// frame geometry, default sync marker and the checksum test.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        OPC  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CHK  = 3'd4
    } deframe_state_t;

    localparam int          FRAME_LEN    = 5;
    localparam logic [7:0]  DEFAULT_SYNC = 8'hA5;

    // A frame is good when opcode, payload and checksum sum to zero mod 256.
    function automatic logic chk_ok(
        input logic [7:0] opc,
        input logic [7:0] dhi,
        input logic [7:0] dlo,
        input logic [7:0] chk
    );
        logic [7:0] sum;
        sum = opc + dhi + dlo + chk;
        return (sum == 8'h00);
    endfunction

endpackage

// File: rtl/byte_tmo_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle
// in which the count reaches TMO_CYCLES-1 without a clearing byte.
module byte_tmo_timer #(
    parameter int TMO_CYCLES = 260400,
    parameter int TMO_W      = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // A byte in the terminal cycle suppresses the expiry.
    assign expire = en && !clr && (cnt_q == TMO_W'(TMO_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + TMO_W'(1);
        if (clr || !en || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Consumes UART bytes, hunts for the sync marker, assembles 5-byte frames and
// presents checksum-validated opcode/data with corrupt/timeout/overrun pulses.
module uart_cmd_deframer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC,
    parameter int         TMO_CYCLES = 260400,
    parameter int         TMO_W      = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        chk_err,
    output logic        tmo_err,
    output logic        ovr_err
);

    deframe_state_t state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        chk_err_q, chk_err_d;
    logic        tmo_err_q, tmo_err_d;
    logic        ovr_err_q, ovr_err_d;
    logic        tmo_expire;

    byte_tmo_timer #(
        .TMO_CYCLES (TMO_CYCLES),
        .TMO_W      (TMO_W)
    ) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_rdy),
        .en     (state_q != HUNT),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            opc_q     <= 8'h00;
            dhi_q     <= 8'h00;
            dlo_q     <= 8'h00;
            cmd_q     <= 8'h00;
            data_q    <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            chk_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            dhi_q     <= dhi_d;
            dlo_q     <= dlo_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            cmd_rdy_q <= cmd_rdy_d;
            chk_err_q <= chk_err_d;
            tmo_err_q <= tmo_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    // A received byte always takes priority over a simultaneous expiry.
    always_comb begin
        state_d = state_q;
        if (rx_rdy) begin
            case (state_q)
                HUNT:    state_d = (rx_data == SYNC_BYTE) ? OPC : HUNT;
                OPC:     state_d = DHI;
                DHI:     state_d = DLO;
                DLO:     state_d = CHK;
                CHK:     state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end else if (tmo_expire) begin
            state_d = HUNT;
        end
    end

    always_comb begin
        opc_d     = opc_q;
        dhi_d     = dhi_q;
        dlo_d     = dlo_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        cmd_rdy_d = cmd_rdy_q && !clr_cmd_rdy;
        chk_err_d = 1'b0;
        ovr_err_d = 1'b0;
        tmo_err_d = tmo_expire && !rx_rdy;
        if (rx_rdy) begin
            case (state_q)
                OPC: opc_d = rx_data;
                DHI: dhi_d = rx_data;
                DLO: dlo_d = rx_data;
                CHK: begin
                    if (chk_ok(opc_q, dhi_q, dlo_q, rx_data)) begin
                        cmd_d     = opc_q;
                        data_d    = {dhi_q, dlo_q};
                        cmd_rdy_d = 1'b1;
                        ovr_err_d = cmd_rdy_q && !clr_cmd_rdy;
                    end else begin
                        chk_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clr_rx_rdy = rx_rdy;
    assign cmd        = cmd_q;
    assign data       = data_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign chk_err    = chk_err_q;
    assign tmo_err    = tmo_err_q;
    assign ovr_err    = ovr_err_q;

endmodule
